atm_session_ctrl: RTL and testbench

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

---
 rtl/atm_pkg.sv | 32 +++
 rtl/atm_session_ctrl_if.sv | 32 +++
 rtl/atm_inactivity_timer.sv | 34 +++
 rtl/atm_session_ctrl.sv | 158 +++++++++++++++
 tb/tb_atm_session_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller.
// The state encoding doubles as the display code driven to the front panel.
package atm_pkg;

    localparam int unsigned DEF_MAX_TRIES   = 3;
    localparam int unsigned DEF_TIMEOUT_CYC = 1000;
    localparam int unsigned DEF_EJECT_CYC   = 4;

    localparam int unsigned TRIES_W = 2;
    localparam int unsigned DISP_W  = 3;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned EJECT_W = 4;

    localparam logic [DISP_W-1:0] DISP_IDLE     = 3'b000;
    localparam logic [DISP_W-1:0] DISP_WAIT_PIN = 3'b001;
    localparam logic [DISP_W-1:0] DISP_SERVICE  = 3'b010;
    localparam logic [DISP_W-1:0] DISP_EJECT    = 3'b011;
    localparam logic [DISP_W-1:0] DISP_RETAIN   = 3'b100;

    typedef enum logic [DISP_W-1:0] {
        ST_IDLE     = DISP_IDLE,
        ST_WAIT_PIN = DISP_WAIT_PIN,
        ST_SERVICE  = DISP_SERVICE,
        ST_EJECT    = DISP_EJECT,
        ST_RETAIN   = DISP_RETAIN
    } state_e;

    function automatic logic [DISP_W-1:0] disp_of(input state_e s);
        return DISP_W'(s);
    endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Card/keypad/transaction signals between the ATM host logic and the session controller.
interface atm_session_ctrl_if;
    import atm_pkg::*;

    logic               card_in;
    logic               pin_valid;
    logic               pin_ok;
    logic               op_done;
    logic               new_transaction;
    logic               key_activity;
    logic               pin_check;
    logic               session_active;
    logic               card_eject;
    logic               card_retain;
    logic               session_abort;
    logic               timeout_flag;
    logic [TRIES_W-1:0] tries_left;
    logic [DISP_W-1:0]  display;

    modport master (
        output card_in, pin_valid, pin_ok, op_done, new_transaction, key_activity,
        input  pin_check, session_active, card_eject, card_retain, session_abort,
               timeout_flag, tries_left, display
    );

    modport slave (
        input  card_in, pin_valid, pin_ok, op_done, new_transaction, key_activity,
        output pin_check, session_active, card_eject, card_retain, session_abort,
               timeout_flag, tries_left, display
    );

endinterface

// File: rtl/atm_inactivity_timer.sv
// Inactivity counter: cleared by activity or when disabled, pulses expire_c on its last count.
module atm_inactivity_timer
    import atm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        expire_c = 1'b0;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (cnt_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
            expire_c = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM card session FSM: PIN attempts, service loop, card eject/retain, abort on removal.
// Inactivity timeout is built only when ATM_SESSION_TIMEOUT_EN is defined.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned MAX_TRIES   = DEF_MAX_TRIES,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned EJECT_CYC   = DEF_EJECT_CYC
) (
    input  logic               clk,
    input  logic               reset,
    atm_session_ctrl_if.slave  bus
);

    state_e             state_q, state_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [EJECT_W-1:0] eject_cnt_q, eject_cnt_d;
    logic               pin_check_q, pin_check_d;
    logic               active_q, active_d;
    logic               eject_q, eject_d;
    logic               retain_q, retain_d;
    logic               abort_q, abort_d;
    logic               tmo_q, tmo_d;
    logic [DISP_W-1:0]  display_q, display_d;
    logic               expire_c;
    logic               go_eject_c;

`ifdef ATM_SESSION_TIMEOUT_EN
    logic timer_en_c;
    logic timer_clr_c;

    assign timer_en_c  = (state_q == ST_WAIT_PIN) || (state_q == ST_SERVICE);
    assign timer_clr_c = bus.pin_valid | bus.op_done | bus.key_activity;

    atm_inactivity_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clr_c),
        .enable   (timer_en_c),
        .expire_c (expire_c)
    );
`else
    logic timer_unused;

    assign timer_unused = bus.key_activity | TIMEOUT_CYC[0];
    assign expire_c     = 1'b0;
`endif

    // Next state and next registered outputs; removal beats strobes, strobes beat timeout.
    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        eject_cnt_d = eject_cnt_q;
        eject_d     = 1'b0;
        abort_d     = 1'b0;
        tmo_d       = 1'b0;
        go_eject_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.card_in) begin
                    state_d = ST_WAIT_PIN;
                    tries_d = TRIES_W'(MAX_TRIES);
                end
            end
            ST_WAIT_PIN: begin
                if (!bus.card_in) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (bus.pin_valid) begin
                    if (bus.pin_ok) begin
                        state_d = ST_SERVICE;
                    end else begin
                        tries_d = (tries_q != '0) ? tries_q - TRIES_W'(1) : '0;
                        if (tries_q <= TRIES_W'(1)) state_d = ST_RETAIN;
                    end
                end else if (expire_c) begin
                    tmo_d      = 1'b1;
                    go_eject_c = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (!bus.card_in) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (bus.op_done) begin
                    go_eject_c = !bus.new_transaction;
                end else if (expire_c) begin
                    tmo_d      = 1'b1;
                    go_eject_c = 1'b1;
                end
            end
            ST_EJECT: begin
                // eject_cnt holds the pulse cycles still owed after the current one
                if (eject_cnt_q != '0) begin
                    eject_d     = 1'b1;
                    eject_cnt_d = eject_cnt_q - EJECT_W'(1);
                end else if (!bus.card_in) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RETAIN: begin
                if (!bus.card_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go_eject_c) begin
            state_d     = ST_EJECT;
            eject_d     = 1'b1;
            eject_cnt_d = EJECT_W'(EJECT_CYC - 1);
        end

        if (state_d == ST_IDLE || state_d == ST_RETAIN) tries_d = (state_d == ST_RETAIN) ? '0 : tries_d;
        if (state_d == ST_IDLE && state_q != ST_IDLE) tries_d = '0;

        pin_check_d = (state_d == ST_SERVICE);
        active_d    = (state_d == ST_WAIT_PIN) || (state_d == ST_SERVICE);
        retain_d    = (state_d == ST_RETAIN);
        display_d   = disp_of(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tries_q     <= '0;
            eject_cnt_q <= '0;
            pin_check_q <= 1'b0;
            active_q    <= 1'b0;
            eject_q     <= 1'b0;
            retain_q    <= 1'b0;
            abort_q     <= 1'b0;
            tmo_q       <= 1'b0;
            display_q   <= DISP_IDLE;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            eject_cnt_q <= eject_cnt_d;
            pin_check_q <= pin_check_d;
            active_q    <= active_d;
            eject_q     <= eject_d;
            retain_q    <= retain_d;
            abort_q     <= abort_d;
            tmo_q       <= tmo_d;
            display_q   <= display_d;
        end
    end

    assign bus.pin_check      = pin_check_q;
    assign bus.session_active = active_q;
    assign bus.card_eject     = eject_q;
    assign bus.card_retain    = retain_q;
    assign bus.session_abort  = abort_q;
    assign bus.timeout_flag   = tmo_q;
    assign bus.tries_left     = tries_q;
    assign bus.display        = display_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: cycle model plus directed scenarios with literal expectations.
// Timeout scenarios run when ATM_SESSION_TIMEOUT_EN is defined; otherwise the no-expiry case runs.
module tb_atm_session_ctrl;

    localparam int MAX_T = 3;
    localparam int TO_C  = 16;
    localparam int EJ_C  = 4;

    logic clk;
    logic reset;
    int   errs;
    int   checks;

    atm_session_ctrl_if bus ();

    atm_session_ctrl #(
        .MAX_TRIES   (MAX_T),
        .TIMEOUT_CYC (TO_C),
        .EJECT_CYC   (EJ_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Session model: phase 0 idle, 1 PIN entry, 2 service, 3 eject, 4 retained.
    int m_ph, m_tries, m_ej;
    bit m_abort, m_tmo;
`ifdef ATM_SESSION_TIMEOUT_EN
    int m_quiet;
`endif

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = 0; m_tries = 0; m_ej = 0; m_abort = 0; m_tmo = 0;
`ifdef ATM_SESSION_TIMEOUT_EN
            m_quiet = 0;
`endif
        end else begin
            m_abort = 0;
            m_tmo   = 0;
            case (m_ph)
                0: if (bus.card_in) begin m_ph = 1; m_tries = MAX_T; end
                1, 2: begin
`ifdef ATM_SESSION_TIMEOUT_EN
                    if (bus.pin_valid || bus.op_done || bus.key_activity) m_quiet = 0;
                    else m_quiet = m_quiet + 1;
`endif
                    if (!bus.card_in) begin
                        m_ph = 0; m_abort = 1; m_tries = 0;
                    end else if (m_ph == 1 && bus.pin_valid) begin
                        if (bus.pin_ok) m_ph = 2;
                        else begin
                            m_tries = (m_tries > 0) ? m_tries - 1 : 0;
                            if (m_tries == 0) m_ph = 4;
                        end
                    end else if (m_ph == 2 && bus.op_done) begin
                        if (!bus.new_transaction) begin m_ph = 3; m_ej = EJ_C; end
                    end
`ifdef ATM_SESSION_TIMEOUT_EN
                    else if (m_quiet == TO_C) begin
                        m_tmo = 1; m_ph = 3; m_ej = EJ_C;
                    end
`endif
                end
                3: begin
                    if (m_ej > 0) m_ej = m_ej - 1;
                    if (m_ej == 0 && !bus.card_in) begin m_ph = 0; m_tries = 0; end
                end
                4: if (!bus.card_in) m_ph = 0;
                default: m_ph = 0;
            endcase
`ifdef ATM_SESSION_TIMEOUT_EN
            if (m_ph != 1 && m_ph != 2) m_quiet = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("display",        32'(bus.display),        32'(m_ph));
            chk("tries_left",     32'(bus.tries_left),     32'(m_tries));
            chk("pin_check",      32'(bus.pin_check),      32'(m_ph == 2));
            chk("session_active", 32'(bus.session_active), 32'(m_ph == 1 || m_ph == 2));
            chk("card_eject",     32'(bus.card_eject),     32'(m_ej > 0));
            chk("card_retain",    32'(bus.card_retain),    32'(m_ph == 4));
            chk("session_abort",  32'(bus.session_abort),  32'(m_abort));
            chk("timeout_flag",   32'(bus.timeout_flag),   32'(m_tmo));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pin(input bit ok);
        bus.pin_valid = 1'b1; bus.pin_ok = ok;
        step();
        bus.pin_valid = 1'b0; bus.pin_ok = 1'b0;
    endtask

    task automatic op(input bit again);
        bus.op_done = 1'b1; bus.new_transaction = again;
        step();
        bus.op_done = 1'b0; bus.new_transaction = 1'b0;
    endtask

    task automatic leave();
        bus.card_in = 1'b0;
        repeat (EJ_C + 2) step();
        chk("back_idle", 32'(bus.display), 32'd0);
    endtask

    int n_ej;

    initial begin
        errs = 0; checks = 0;
        reset = 1'b1;
        bus.card_in = 1'b1; bus.pin_valid = 1'b0; bus.pin_ok = 1'b0;
        bus.op_done = 1'b0; bus.new_transaction = 1'b0; bus.key_activity = 1'b0;
        repeat (3) step();
        chk("rst_display", 32'(bus.display), 32'd0);
        chk("rst_tries",   32'(bus.tries_left), 32'd0);
        chk("rst_active",  32'(bus.session_active), 32'd0);

        // card already present at release: PIN entry after first edge
        reset = 1'b0;
        step();
        chk("wait_disp",  32'(bus.display), 32'd1);
        chk("wait_tries", 32'(bus.tries_left), 32'd3);

        // good PIN, one repeat transaction, then finish and eject
        pin(1'b1);
        chk("svc_disp", 32'(bus.display), 32'd2);
        chk("svc_pin_check", 32'(bus.pin_check), 32'd1);
        op(1'b1);
        chk("svc_again", 32'(bus.display), 32'd2);
        op(1'b0);
        chk("ej_disp", 32'(bus.display), 32'd3);
        n_ej = 32'(bus.card_eject);
        repeat (6) begin step(); n_ej += 32'(bus.card_eject); end
        chk("ej_width", 32'(n_ej), 32'd4);
        chk("ej_hold_card", 32'(bus.display), 32'd3);
        bus.card_in = 1'b0; step();
        chk("ej_to_idle", 32'(bus.display), 32'd0);

        // three wrong PINs retain the card; further strobes ignored
        bus.card_in = 1'b1; step();
        pin(1'b0); chk("tries_2", 32'(bus.tries_left), 32'd2);
        pin(1'b0); chk("tries_1", 32'(bus.tries_left), 32'd1);
        pin(1'b0); chk("tries_0", 32'(bus.tries_left), 32'd0);
        chk("ret_disp", 32'(bus.display), 32'd4);
        chk("ret_flag", 32'(bus.card_retain), 32'd1);
        pin(1'b0); op(1'b0);
        chk("ret_sat", 32'(bus.tries_left), 32'd0);
        bus.card_in = 1'b0; step();
        chk("ret_release", 32'(bus.display), 32'd0);

        // card pulled in SERVICE together with op_done
        bus.card_in = 1'b1; step(); pin(1'b1);
        bus.card_in = 1'b0; op(1'b0);
        chk("abort_svc", 32'(bus.session_abort), 32'd1);
        chk("abort_no_eject", 32'(bus.card_eject), 32'd0);
        step();
        chk("abort_pulse", 32'(bus.session_abort), 32'd0);

        // card pulled in PIN entry together with a good PIN
        bus.card_in = 1'b1; step();
        bus.card_in = 1'b0; pin(1'b1);
        chk("abort_pin", 32'(bus.session_abort), 32'd1);
        chk("abort_pin_disp", 32'(bus.display), 32'd0);

`ifdef ATM_SESSION_TIMEOUT_EN
        // silent SERVICE expires after 16 cycles
        bus.card_in = 1'b1; step(); pin(1'b1);
        repeat (15) step();
        chk("to_not_yet", 32'(bus.display), 32'd2);
        step();
        chk("to_flag", 32'(bus.timeout_flag), 32'd1);
        chk("to_eject", 32'(bus.display), 32'd3);
        leave();

        // key press on cycle 10 pushes expiry out by 10 cycles
        bus.card_in = 1'b1; step(); pin(1'b1);
        repeat (9) step();
        bus.key_activity = 1'b1; step(); bus.key_activity = 1'b0;
        repeat (15) step();
        chk("key_not_yet", 32'(bus.timeout_flag), 32'd0);
        step();
        chk("key_flag", 32'(bus.timeout_flag), 32'd1);
        leave();
`else
        // no timer: an idle session never expires
        bus.card_in = 1'b1; step(); pin(1'b1);
        n_ej = 0;
        repeat (100) begin step(); n_ej += 32'(bus.timeout_flag); end
        chk("no_to_flag", 32'(n_ej), 32'd0);
        chk("no_to_disp", 32'(bus.display), 32'd2);
        op(1'b0);
        leave();
`endif

        // reset in the middle of the eject pulse
        bus.card_in = 1'b1; step(); pin(1'b1); op(1'b0);
        step();
        chk("pre_rst_eject", 32'(bus.card_eject), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_eject", 32'(bus.card_eject), 32'd0);
        chk("rst_disp", 32'(bus.display), 32'd0);
        bus.card_in = 1'b0;
        step(); step();
        reset = 1'b0;
        repeat (3) step();
        chk("post_rst_idle", 32'(bus.display), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
